// File: rtl/queue_cal_pkg.sv
// Shared constants for the calculator queue blocks: queue opcodes, token kinds,
// ALU operations and sequencer states.
package queue_cal_pkg;

  localparam int DEPTH_DEF = 5;

  typedef logic [1:0] opcode_t;
  typedef logic [1:0] kind_t;
  typedef logic [1:0] aluop_t;
  typedef logic [1:0] state_t;

  localparam opcode_t OP_PUSH    = 2'b00;
  localparam opcode_t OP_NOP     = 2'b01;
  localparam opcode_t OP_COMBINE = 2'b10;
  localparam opcode_t OP_POP     = 2'b11;

  localparam kind_t TK_OPERAND  = 2'b00;
  localparam kind_t TK_OPERATOR = 2'b01;
  localparam kind_t TK_RESULT   = 2'b10;
  localparam kind_t TK_DROP     = 2'b11;

  localparam aluop_t ALU_ADD = 2'b00;
  localparam aluop_t ALU_SUB = 2'b01;
  localparam aluop_t ALU_AND = 2'b10;
  localparam aluop_t ALU_XOR = 2'b11;

  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_EXEC = 2'b01;
  localparam state_t ST_EMIT = 2'b10;
  localparam state_t ST_ERR  = 2'b11;

endpackage

// File: rtl/queue_alu.sv
// Combinational ALU for the calculator queue; results wrap modulo 2^WIDTH.
module queue_alu
  import queue_cal_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_XOR: y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/queue_op_sequencer.sv
// Token-driven controller for the calculator queue: validates tokens against the
// queue occupancy, issues one queue command per token and returns popped values.
module queue_op_sequencer
  import queue_cal_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_kind,
  input  logic [WIDTH-1:0]   in_data,
  output logic [1:0]         q_opcode,
  output logic [WIDTH-1:0]   q_back,
  input  logic [2*WIDTH-1:0] q_top_conc,
  input  logic [2:0]         q_pos_back,
  input  logic               q_is_err,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_data,
  output logic               err
);

  localparam logic [2:0] DEPTH_L = 3'(DEPTH);

  state_t           state_q, state_d;
  opcode_t          cmd_q, cmd_d;
  logic             emit_q, emit_d;
  logic [WIDTH-1:0] q_back_q, q_back_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             in_ready_q, in_ready_d;
  opcode_t          q_opcode_q, q_opcode_d;
  logic             res_valid_q, res_valid_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic             accept;
  logic             legal;

  assign alu_a = q_top_conc[2*WIDTH-1:WIDTH];
  assign alu_b = q_top_conc[WIDTH-1:0];

  queue_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (in_data[1:0]),
    .y  (alu_y)
  );

  // in_ready_q is only ever high while in IDLE, so it doubles as the accept gate
  assign accept = in_valid & in_ready_q;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    emit_d     = emit_q;
    q_back_d   = q_back_q;
    res_data_d = res_data_q;
    legal      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (in_kind)
            TK_OPERAND:  legal = (q_pos_back < DEPTH_L);
            TK_OPERATOR: legal = (q_pos_back >= 3'd2);
            default:     legal = (q_pos_back >= 3'd1);
          endcase
          if (legal) begin
            state_d = ST_EXEC;
            emit_d  = 1'b0;
            case (in_kind)
              TK_OPERAND: begin
                cmd_d    = OP_PUSH;
                q_back_d = in_data;
              end
              TK_OPERATOR: begin
                cmd_d    = OP_COMBINE;
                q_back_d = alu_y;
              end
              TK_RESULT: begin
                cmd_d      = OP_POP;
                res_data_d = alu_a;
                emit_d     = 1'b1;
              end
              default: cmd_d = OP_POP;
            endcase
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_EXEC: state_d = emit_q ? ST_EMIT : ST_IDLE;
      ST_EMIT: if (res_ready) state_d = ST_IDLE;
      default: state_d = ST_ERR;
    endcase

    // A queue fault overrides everything, including a pending emit
    if (q_is_err) state_d = ST_ERR;
  end

  // Registered outputs are decoded from the next state so they align with it
  always_comb begin
    in_ready_d  = (state_d == ST_IDLE);
    q_opcode_d  = (state_d == ST_EXEC) ? cmd_d : OP_NOP;
    res_valid_d = (state_d == ST_EMIT);
    err_d       = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= OP_NOP;
      emit_q      <= 1'b0;
      q_back_q    <= '0;
      res_data_q  <= '0;
      in_ready_q  <= 1'b0;
      q_opcode_q  <= OP_NOP;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      emit_q      <= emit_d;
      q_back_q    <= q_back_d;
      res_data_q  <= res_data_d;
      in_ready_q  <= in_ready_d;
      q_opcode_q  <= q_opcode_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign q_opcode  = q_opcode_q;
  assign q_back    = q_back_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_queue_op_sequencer.sv
// Bench for queue_op_sequencer: a behavioural 5-entry queue fixture answers the
// commands, and a list-based calculator model predicts every command and result.
module tb_queue_op_sequencer;

  localparam int W = 8;
  localparam int D = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [1:0]     in_kind = 2'b00;
  logic [W-1:0]   in_data = '0;
  logic [1:0]     q_opcode;
  logic [W-1:0]   q_back;
  logic [2*W-1:0] q_top_conc;
  logic [2:0]     q_pos_back;
  logic           q_is_err;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [W-1:0]   res_data;
  logic           err;

  always #5 clk = ~clk;

  queue_op_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_data    (in_data),
    .q_opcode   (q_opcode),
    .q_back     (q_back),
    .q_top_conc (q_top_conc),
    .q_pos_back (q_pos_back),
    .q_is_err   (q_is_err),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .err        (err)
  );

  int ncomp = 0;
  int nfail = 0;

  // Queue fixture: entry 0 is the front (oldest); combine replaces the front two
  logic [W-1:0] ent [0:7];
  int           cnt;
  logic         fx_err;
  logic         force_qerr = 1'b0;
  int           n_push, n_comb, n_pop;

  assign q_top_conc = {ent[0], ent[1]};
  assign q_pos_back = cnt[2:0];
  assign q_is_err   = fx_err | force_qerr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 0;
      fx_err <= 1'b0;
      n_push <= 0;
      n_comb <= 0;
      n_pop  <= 0;
      for (int i = 0; i < 8; i++) ent[i] <= '0;
    end else begin
      case (q_opcode)
        2'b00: begin
          n_push <= n_push + 1;
          if (cnt >= D) fx_err <= 1'b1;
          else begin
            ent[cnt] <= q_back;
            cnt      <= cnt + 1;
          end
        end
        2'b10: begin
          n_comb <= n_comb + 1;
          if (cnt < 2) fx_err <= 1'b1;
          else begin
            ent[0] <= q_back;
            for (int i = 1; i < 7; i++) ent[i] <= ent[i+1];
            ent[7] <= '0;
            cnt    <= cnt - 1;
          end
        end
        2'b11: begin
          n_pop <= n_pop + 1;
          if (cnt < 1) fx_err <= 1'b1;
          else begin
            for (int i = 0; i < 7; i++) ent[i] <= ent[i+1];
            ent[7] <= '0;
            cnt    <= cnt - 1;
          end
        end
        default: ;
      endcase
    end
  end

  // Calculator reference model
  int mq[$];
  bit m_err;

  function automatic int alu_ref(input int a, input int b, input int op);
    case (op)
      0:       return (a + b) % 256;
      1:       return (a - b + 256) % 256;
      2:       return a & b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for in_ready at a negedge; returns 1 if ready
  task automatic wait_ready(output bit ok);
    int t;
    t = 0;
    while (in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    ok = (in_ready === 1'b1);
    check("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  // Sends one token from a negedge and checks everything up to its completion
  task automatic token(input logic [1:0] k, input logic [W-1:0] d, input int hold);
    bit ok, legal, emit;
    int exp_cmd, exp_back, exp_res, a, b;
    logic [W-1:0] held;
    legal = 0; emit = 0; exp_cmd = 1; exp_back = 0; exp_res = 0;
    case (k)
      2'b00: begin legal = (mq.size() < D); exp_cmd = 0; exp_back = int'(d); end
      2'b01: begin
        legal = (mq.size() >= 2); exp_cmd = 2;
        if (legal) exp_back = alu_ref(mq[0], mq[1], int'(d[1:0]));
      end
      2'b10: begin legal = (mq.size() >= 1); exp_cmd = 3; emit = 1; if (legal) exp_res = mq[0]; end
      default: begin legal = (mq.size() >= 1); exp_cmd = 3; end
    endcase

    wait_ready(ok);
    if (!ok) return;
    in_valid = 1'b1;
    in_kind  = k;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_kind  = 2'($urandom);
    in_data  = W'($urandom);

    if (!legal) begin
      check("illegal_nop", 32'(q_opcode), 32'd1);
      check("illegal_err", 32'(err), 32'd1);
      check("illegal_rdy", 32'(in_ready), 32'd0);
      m_err = 1;
      return;
    end
    check("cmd", 32'(q_opcode), 32'(exp_cmd));
    if (k == 2'b00 || k == 2'b01) check("q_back", 32'(q_back), 32'(exp_back));

    case (k)
      2'b00: mq.push_back(int'(d));
      2'b01: begin
        a = mq.pop_front();
        b = mq.pop_front();
        mq.push_front(alu_ref(a, b, int'(d[1:0])));
      end
      default: void'(mq.pop_front());
    endcase

    @(negedge clk);
    check("cmd_one_cycle", 32'(q_opcode), 32'd1);
    check("occupancy", 32'(q_pos_back), 32'(mq.size()));
    check("err_clear", 32'(err), 32'd0);
    if (emit) begin
      check("res_valid", 32'(res_valid), 32'd1);
      check("res_data", 32'(res_data), 32'(exp_res));
      check("rdy_in_emit", 32'(in_ready), 32'd0);
      held = res_data;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("res_valid_hold", 32'(res_valid), 32'd1);
        check("res_data_hold", 32'(res_data), 32'(held));
        check("rdy_hold", 32'(in_ready), 32'd0);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("res_valid_drop", 32'(res_valid), 32'd0);
      check("rdy_after_hs", 32'(in_ready), 32'd1);
    end else begin
      check("rdy_return", 32'(in_ready), 32'd1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_opcode", 32'(q_opcode), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_q_back", 32'(q_back), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_err = 0;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int c0, p0, u0;
    bit ok;
    int r;
    m_err = 0;

    do_reset();

    // add then result
    c0 = n_comb; p0 = n_pop;
    token(2'b00, 8'd3, 0);
    token(2'b00, 8'd5, 0);
    token(2'b01, 8'h00, 0);
    token(2'b10, 8'h00, 0);
    check("add_comb_count", 32'(n_comb - c0), 32'd1);
    check("add_pop_count", 32'(n_pop - p0), 32'd1);
    check("add_err", 32'(err), 32'd0);

    // subtraction wrap and xor
    token(2'b00, 8'd3, 0);
    token(2'b00, 8'd5, 0);
    token(2'b01, 8'h01, 1);
    token(2'b10, 8'h00, 1);
    token(2'b00, 8'hF0, 0);
    token(2'b00, 8'h3C, 0);
    token(2'b01, 8'h03, 0);
    token(2'b10, 8'h00, 2);

    // overflow: sixth operand
    u0 = n_push;
    for (int i = 0; i < 6; i++) token(2'b00, 8'(i + 1), 0);
    check("ovf_push_count", 32'(n_push - u0), 32'd5);
    repeat (3) @(negedge clk);
    check("ovf_err_sticky", 32'(err), 32'd1);
    check("ovf_rdy_low", 32'(in_ready), 32'd0);
    do_reset();

    // operator with one entry
    c0 = n_comb;
    token(2'b00, 8'd9, 0);
    token(2'b01, 8'h00, 0);
    @(negedge clk);
    check("underflow_no_comb", 32'(n_comb - c0), 32'd0);
    check("underflow_err", 32'(err), 32'd1);
    do_reset();

    // result with backpressure
    p0 = n_pop;
    token(2'b00, 8'd7, 0);
    token(2'b10, 8'h00, 4);
    check("bp_pop_count", 32'(n_pop - p0), 32'd1);

    // reset during EMIT
    token(2'b00, 8'd7, 0);
    wait_ready(ok);
    in_valid = 1'b1; in_kind = 2'b10; in_data = '0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_emit", 32'(res_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_emit_valid", 32'(res_valid), 32'd0);
    check("rst_emit_err", 32'(err), 32'd0);
    check("rst_emit_opcode", 32'(q_opcode), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_err = 0;
    @(negedge clk);
    check("rst_emit_ready", 32'(in_ready), 32'd1);

    // queue error abandons EMIT
    token(2'b00, 8'd1, 0);
    wait_ready(ok);
    in_valid = 1'b1; in_kind = 2'b10; in_data = '0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    force_qerr = 1'b1;
    @(negedge clk);
    force_qerr = 1'b0;
    check("qerr_err", 32'(err), 32'd1);
    check("qerr_valid", 32'(res_valid), 32'd0);
    check("qerr_ready", 32'(in_ready), 32'd0);
    do_reset();

    // randomized token stream
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      token(2'b00, 8'($urandom), 0);
      else if (r < 7) token(2'b01, 8'($urandom), 0);
      else if (r < 9) token(2'b10, 8'h00, $urandom_range(0, 3));
      else            token(2'b11, 8'h00, 0);
      if (m_err) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/queue_op_sequencer.md
# queue_op_sequencer

Token-driven controller for the 5-entry calculator queue. It accepts a stream of operand and operator tokens and issues the matching push, combine or pop commands on the queue's opcode/data port. Combine results come from a local ALU fed by the queue's first-two-entries bus. Popped head values are returned on a valid/ready result stream, and illegal sequences are caught before they reach the queue.

## Interface
Parameters:
- WIDTH, 8, entry/data width
- DEPTH, 5, queue capacity (must match the queue)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  token valid
- in_ready  out  1  token accepted when in_valid & in_ready
- in_kind  in  2  00 operand, 01 operator, 10 result (pop and emit), 11 drop (pop, no emit)
- in_data  in  WIDTH  operand value; [1:0] = ALU op for operator tokens
- q_opcode  out  2  queue command: 00 push, 10 combine, 11 pop front, 01 no-op
- q_back  out  WIDTH  data for push/combine
- q_top_conc  in  2*WIDTH  {entry0, entry1} from queue
- q_pos_back  in  3  queue occupancy
- q_is_err  in  1  queue sticky error
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_data  out  WIDTH  popped head value
- err  out  1  sticky protocol error

## Operation
- States: IDLE, EXEC, EMIT, ERR.
- IDLE:
  - in_ready=1; q_opcode=01.
  - On accept, check the token against the current q_pos_back:
    - operand: legal if pos<DEPTH; q_back<=in_data, cmd 00.
    - operator: legal if pos>=2; q_back<=alu(a=q_top_conc[2W-1:W], b=q_top_conc[W-1:0], op=in_data[1:0]), cmd 10.
    - result: legal if pos>=1; res_data<=a, cmd 11, set emit flag.
    - drop: legal if pos>=1; cmd 11.
  - Legal token -> EXEC. Illegal token -> ERR, and no command is issued.
- EXEC:
  - q_opcode=cmd for exactly one cycle.
  - Then EMIT if the emit flag is set, else IDLE.
- EMIT:
  - res_valid=1, res_data stable.
  - On res_ready -> IDLE.
- ERR:
  - err=1, in_ready=0, q_opcode=01.
  - Left only by rst.
- q_is_err=1 in any state -> ERR at the next edge, and any pending EMIT is abandoned.
- ALU ops: 00 a+b, 01 a-b, 10 a&b, 11 a^b. Results are modulo 2^WIDTH with no carry or borrow output.
- in_kind/in_data are ignored when in_valid=0.

## Timing
- All outputs are registered.
- Reset values: q_opcode=01, q_back=0, res_valid=0, res_data=0, err=0, state=IDLE.
  - in_ready=0 while rst is asserted.
  - in_ready=1 in the first cycle after rst is released.
- Token accepted in cycle N:
  - q_opcode holds the command during N+1.
  - The queue updates at the end of N+1.
  - in_ready returns in N+2 (non-emit tokens), so peak throughput is 1 token per 2 cycles.
- Result token: res_valid rises in N+2 and holds until the res_ready handshake. in_ready is 0 throughout.
- The legality check uses q_pos_back sampled in the accept cycle. This value is always settled because IDLE is never entered in the same cycle a command executes.
- ALU operands are sampled in the accept cycle. The combine is issued in N+1 using the registered q_back.
- rst mid-operation (any state) returns immediately to the reset values. The queue shares rst, so no command is left half-issued.
- The opcode 01 no-op is driven in every cycle except EXEC.

## Structure
- Shared package `queue_cal_pkg`:
  - queue opcode constants (PUSH=00, NOP=01, COMBINE=10, POP=11)
  - token kind constants
  - ALU op constants
  - state enum
  - DEPTH default
- Sub-module `queue_alu`: combinational, WIDTH-parameterised, inputs a, b, op, output y. It is reused by future calculator blocks.
- Top level: FSM, command/data registers, result register.

## Test plan
- Push 3, push 5, operator add, result -> one 10 cycle then one 11 cycle on q_opcode; res_data=8; err=0.
- Push 3, push 5, operator sub, result -> res_data=0xFE (wrap); push 0xF0, push 0x3C, operator xor, result -> 0xCC.
- Six operand tokens -> first five issue 00, sixth sets err the next cycle with no 00 cycle for it; in_ready stays 0 afterwards.
- Single push then operator token -> err=1; q_opcode never shows 10.
- Push 7, result with res_ready held low 4 cycles -> res_valid=1 and res_data=7 stable; exactly one 11 cycle; in_ready returns the cycle after the handshake.
- Assert rst during EMIT -> res_valid=0, err=0 and q_opcode=01 immediately; in_ready=1 the cycle after rst is released.
